// File: rtl/bus_decoder_if.sv
// Core-side bus, region selects/data and debug/counter observation signals of the address decoder.
// master = core/environment side, slave = decoder side.
interface bus_decoder_if #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8
);
    logic [ADDR_W-1:0]             address;
    logic                          nread;
    logic                          nwrite;
    logic [DATA_W-1:0]             wdata;
    logic [DATA_W-1:0]             rdata;
    logic                          ready;
    logic [NUM_REGIONS-1:0]        nsel;
    logic [NUM_REGIONS*DATA_W-1:0] region_rdata;
    logic                          dbg_valid;
    logic [DATA_W-1:0]             dbg_data;
    logic [7:0]                    unmapped_cnt;
    logic [7:0]                    proto_err_cnt;

    modport master (
        output address, nread, nwrite, wdata, region_rdata,
        input  rdata, ready, nsel, dbg_valid, dbg_data, unmapped_cnt, proto_err_cnt
    );

    modport slave (
        input  address, nread, nwrite, wdata, region_rdata,
        output rdata, ready, nsel, dbg_valid, dbg_data, unmapped_cnt, proto_err_cnt
    );
endinterface

// File: rtl/bus_decoder.sv
// Address decoder: registered active-low region selects, per-region wait states, one-cycle ready.
// Ready comes 1+W edges after the request edge; core holds strobes, dropping them mid-wait aborts.
module bus_decoder #(
    parameter int                          NUM_REGIONS = 4,
    parameter int                          ADDR_W      = 16,
    parameter int                          DATA_W      = 8,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = {16'hFFFF, 16'hFF80, 16'hC000, 16'h0000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = {16'hFFFF, 16'hFF80, 16'hE000, 16'h8000},
    parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT = {4'd0, 4'd0, 4'd1, 4'd2},
    parameter logic [DATA_W-1:0]             OPEN_BUS    = 8'hFF,
    parameter logic [ADDR_W-1:0]             DEBUG_ADDR  = 16'hFF01
) (
    input  logic         clock,
    input  logic         reset,
    bus_decoder_if.slave bus
);
    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]     hit_idx_q, hit_idx_d;
    logic                 hit_vld_q, hit_vld_d;
    logic                 is_wr_q, is_wr_d;
    logic                 is_proto_q, is_proto_d;
    logic                 dbg_hit_q, dbg_hit_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [NUM_REGIONS-1:0] nsel_q, nsel_d;
    logic                 ready_q, ready_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 dbg_valid_q, dbg_valid_d;
    logic [DATA_W-1:0]    dbg_data_q, dbg_data_d;
    logic [7:0]           unm_cnt_q, unm_cnt_d;
    logic [7:0]           perr_cnt_q, perr_cnt_d;

    logic                 strobes_idle;
    logic                 req_wr;
    logic                 req_proto;
    logic [IDX_W-1:0]     dec_idx;
    logic                 dec_hit;

    assign strobes_idle = bus.nread & bus.nwrite;
    assign req_wr       = bus.nread & ~bus.nwrite;
    assign req_proto    = ~bus.nread & ~bus.nwrite;

    // Region 0 sits in the most significant slice of the base/mask/wait parameters;
    // scanning downwards lets the lowest matching index win.
    always_comb begin
        dec_idx = '0;
        dec_hit = 1'b0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((bus.address & REGION_MASK[(NUM_REGIONS-1-i)*ADDR_W +: ADDR_W]) ==
                REGION_BASE[(NUM_REGIONS-1-i)*ADDR_W +: ADDR_W]) begin
                dec_idx = IDX_W'(i);
                dec_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort has priority over the wait counter expiring.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (!strobes_idle) state_d = S_WAIT;
            S_WAIT: begin
                if (strobes_idle)       state_d = S_IDLE;
                else if (cnt_q == 4'd0) state_d = S_ACK;
            end
            S_ACK:     state_d = strobes_idle ? S_IDLE : S_RELEASE;
            S_RELEASE: if (strobes_idle) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        hit_idx_d   = hit_idx_q;
        hit_vld_d   = hit_vld_q;
        is_wr_d     = is_wr_q;
        is_proto_d  = is_proto_q;
        dbg_hit_d   = dbg_hit_q;
        wdata_d     = wdata_q;
        nsel_d      = nsel_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        dbg_valid_d = 1'b0;
        dbg_data_d  = dbg_data_q;
        unm_cnt_d   = unm_cnt_q;
        perr_cnt_d  = perr_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!strobes_idle) begin
                    hit_vld_d  = dec_hit & ~req_proto;
                    hit_idx_d  = dec_idx;
                    is_wr_d    = req_wr;
                    is_proto_d = req_proto;
                    dbg_hit_d  = req_wr && (bus.address == DEBUG_ADDR);
                    wdata_d    = bus.wdata;
                    nsel_d     = '1;
                    cnt_d      = 4'd0;
                    if (dec_hit && !req_proto) begin
                        nsel_d[dec_idx] = 1'b0;
                        cnt_d = REGION_WAIT[(NUM_REGIONS-1-int'(dec_idx))*4 +: 4];
                    end
                end
            end
            S_WAIT: begin
                if (strobes_idle) begin
                    nsel_d = '1;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    if (hit_vld_q && !is_wr_q)
                        rdata_d = bus.region_rdata[int'(hit_idx_q)*DATA_W +: DATA_W];
                    else
                        rdata_d = OPEN_BUS;
                    dbg_valid_d = dbg_hit_q;
                    if (dbg_hit_q) dbg_data_d = wdata_q;
                    if (is_proto_q) begin
                        if (perr_cnt_q != 8'hFF) perr_cnt_d = perr_cnt_q + 8'd1;
                    end else if (!hit_vld_q) begin
                        if (unm_cnt_q != 8'hFF) unm_cnt_d = unm_cnt_q + 8'd1;
                    end
                end
            end
            S_ACK:     nsel_d = '1;
            S_RELEASE: nsel_d = '1;
            default:   nsel_d = '1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            hit_idx_q   <= '0;
            hit_vld_q   <= 1'b0;
            is_wr_q     <= 1'b0;
            is_proto_q  <= 1'b0;
            dbg_hit_q   <= 1'b0;
            wdata_q     <= '0;
            nsel_q      <= '1;
            ready_q     <= 1'b0;
            rdata_q     <= OPEN_BUS;
            dbg_valid_q <= 1'b0;
            dbg_data_q  <= '0;
            unm_cnt_q   <= '0;
            perr_cnt_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            hit_idx_q   <= hit_idx_d;
            hit_vld_q   <= hit_vld_d;
            is_wr_q     <= is_wr_d;
            is_proto_q  <= is_proto_d;
            dbg_hit_q   <= dbg_hit_d;
            wdata_q     <= wdata_d;
            nsel_q      <= nsel_d;
            ready_q     <= ready_d;
            rdata_q     <= rdata_d;
            dbg_valid_q <= dbg_valid_d;
            dbg_data_q  <= dbg_data_d;
            unm_cnt_q   <= unm_cnt_d;
            perr_cnt_q  <= perr_cnt_d;
        end
    end

    assign bus.nsel          = nsel_q;
    assign bus.ready         = ready_q;
    assign bus.rdata         = rdata_q;
    assign bus.dbg_valid     = dbg_valid_q;
    assign bus.dbg_data      = dbg_data_q;
    assign bus.unmapped_cnt  = unm_cnt_q;
    assign bus.proto_err_cnt = perr_cnt_q;
endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder: inputs driven and outputs sampled 1ns after each rising edge.
module tb_bus_decoder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    bus_decoder_if #(.NUM_REGIONS(4), .ADDR_W(16), .DATA_W(8)) bus ();

    bus_decoder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_nsel"},  32'(bus.nsel), 32'hF);
        chk({tag, "_ready"}, 32'(bus.ready), 32'h0);
        chk({tag, "_rdata"}, 32'(bus.rdata), 32'hFF);
        chk({tag, "_dbgv"},  32'(bus.dbg_valid), 32'h0);
        chk({tag, "_dbgd"},  32'(bus.dbg_data), 32'h0);
        chk({tag, "_unm"},   32'(bus.unmapped_cnt), 32'h0);
        chk({tag, "_perr"},  32'(bus.proto_err_cnt), 32'h0);
    endtask

    initial begin
        bus.address      = 16'h0000;
        bus.nread        = 1'b1;
        bus.nwrite       = 1'b1;
        bus.wdata        = 8'h00;
        // region 3 -> D3, region 2 -> C2, region 1 -> B1, region 0 -> A0
        bus.region_rdata = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        step();
        step();
        reset = 1'b0;
        chk_reset_state("rst");

        // 1: read 0x0100, region 3, two wait states
        bus.address = 16'h0100;
        bus.nread   = 1'b0;
        step();
        chk("t1_nsel_e0", 32'(bus.nsel), 32'h7);
        chk("t1_rdy_e0", 32'(bus.ready), 32'h0);
        bus.address = 16'hFFFF;
        step();
        chk("t1_rdy_e1", 32'(bus.ready), 32'h0);
        step();
        chk("t1_rdy_e2", 32'(bus.ready), 32'h0);
        chk("t1_nsel_e2", 32'(bus.nsel), 32'h7);
        step();
        chk("t1_rdy_e3", 32'(bus.ready), 32'h1);
        chk("t1_rdata", 32'(bus.rdata), 32'hD3);
        bus.nread = 1'b1;
        step();
        chk("t1_rdy_drop", 32'(bus.ready), 32'h0);
        chk("t1_nsel_rel", 32'(bus.nsel), 32'hF);

        // 2: read 0xFFFF hits regions 0 and 1, region 0 wins, no wait
        bus.address = 16'hFFFF;
        bus.nread   = 1'b0;
        step();
        chk("t2_nsel_e0", 32'(bus.nsel), 32'hE);
        chk("t2_rdy_e0", 32'(bus.ready), 32'h0);
        step();
        chk("t2_rdy_e1", 32'(bus.ready), 32'h1);
        chk("t2_rdata", 32'(bus.rdata), 32'hA0);
        bus.nread = 1'b1;
        step();
        chk("t2_rdy_drop", 32'(bus.ready), 32'h0);

        // 3: read 0xA000 is unmapped
        bus.address = 16'hA000;
        bus.nread   = 1'b0;
        step();
        chk("t3_nsel_e0", 32'(bus.nsel), 32'hF);
        step();
        chk("t3_rdy_e1", 32'(bus.ready), 32'h1);
        chk("t3_rdata", 32'(bus.rdata), 32'hFF);
        chk("t3_unm", 32'(bus.unmapped_cnt), 32'h1);
        chk("t3_nsel_e1", 32'(bus.nsel), 32'hF);
        bus.nread = 1'b1;
        step();

        // 4: write 0xFF01. With the default masks 0xFF01 decodes to no region
        // (0xFF01 & 0xFF80 = 0xFF00), so it is an unmapped write that still hits the debug port.
        bus.address = 16'hFF01;
        bus.wdata   = 8'h41;
        bus.nwrite  = 1'b0;
        step();
        chk("t4_nsel_e0", 32'(bus.nsel), 32'hF);
        chk("t4_dbgv_e0", 32'(bus.dbg_valid), 32'h0);
        bus.address = 16'h0100;
        bus.wdata   = 8'h00;
        step();
        chk("t4_rdy_e1", 32'(bus.ready), 32'h1);
        chk("t4_dbgv_e1", 32'(bus.dbg_valid), 32'h1);
        chk("t4_dbgd", 32'(bus.dbg_data), 32'h41);
        chk("t4_rdata", 32'(bus.rdata), 32'hFF);
        chk("t4_unm", 32'(bus.unmapped_cnt), 32'h2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_hold_rdy", 32'(bus.ready), 32'h0);
            chk("t4_hold_dbgv", 32'(bus.dbg_valid), 32'h0);
            chk("t4_hold_nsel", 32'(bus.nsel), 32'hF);
        end
        bus.nwrite = 1'b1;
        step();
        chk("t4_unm_after", 32'(bus.unmapped_cnt), 32'h2);
        chk("t4_dbgd_keep", 32'(bus.dbg_data), 32'h41);

        // 5: both strobes low is a protocol error, treated as unmapped
        bus.address = 16'h0100;
        bus.nread   = 1'b0;
        bus.nwrite  = 1'b0;
        step();
        chk("t5_nsel_e0", 32'(bus.nsel), 32'hF);
        step();
        chk("t5_rdy_e1", 32'(bus.ready), 32'h1);
        chk("t5_rdata", 32'(bus.rdata), 32'hFF);
        chk("t5_perr", 32'(bus.proto_err_cnt), 32'h1);
        chk("t5_unm", 32'(bus.unmapped_cnt), 32'h2);
        bus.nread  = 1'b1;
        bus.nwrite = 1'b1;
        step();
        for (int i = 0; i < 253; i++) begin
            bus.nread  = 1'b0;
            bus.nwrite = 1'b0;
            step();
            step();
            bus.nread  = 1'b1;
            bus.nwrite = 1'b1;
            step();
        end
        chk("t5_perr_254", 32'(bus.proto_err_cnt), 32'hFE);
        for (int i = 0; i < 47; i++) begin
            bus.nread  = 1'b0;
            bus.nwrite = 1'b0;
            step();
            step();
            bus.nread  = 1'b1;
            bus.nwrite = 1'b1;
            step();
        end
        chk("t5_perr_sat", 32'(bus.proto_err_cnt), 32'hFF);
        chk("t5_unm_keep", 32'(bus.unmapped_cnt), 32'h2);

        // 6: read 0xC000 (region 2, one wait), abort by dropping strobes after E1
        bus.address = 16'hC000;
        bus.nread   = 1'b0;
        step();
        chk("t6_nsel_e0", 32'(bus.nsel), 32'hB);
        step();
        chk("t6_rdy_e1", 32'(bus.ready), 32'h0);
        bus.nread = 1'b1;
        step();
        chk("t6_abort_rdy", 32'(bus.ready), 32'h0);
        chk("t6_abort_nsel", 32'(bus.nsel), 32'hF);
        step();
        chk("t6_abort_rdy2", 32'(bus.ready), 32'h0);

        // 6b: same access, reset asserted while waiting
        bus.nread = 1'b0;
        step();
        chk("t6b_nsel_e0", 32'(bus.nsel), 32'hB);
        reset = 1'b1;
        step();
        chk_reset_state("t6b_rst");
        reset     = 1'b0;
        bus.nread = 1'b1;
        step();
        chk("t6b_rdy_after", 32'(bus.ready), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
